norm_corr_seq_ctrl: RTL and testbench
=====================================

// Module: norm_corr_seq_ctrl
// PURPOSE
//  Sequencer for the normalise+correlate datapath (norm -> 11-disparity corr bank).
//  Owns dp_wen: accepts pixel samples on a valid/ready handshake and advances the datapath one step per sample.
//  Tracks pipeline latency and flushes the pipe at end of line.
//  Snapshots the corr bank, serially selects the best disparity, and presents it on a valid/ready output.
// PARAMETERS
//  NUM_DISP  11  number of correlation outputs on corr_bus (disparities 0..NUM_DISP-1)
//  PIPE_LAT  6   dp_wen pulses from a sample's pulse until its corr result is on corr_bus
//  COL_W     12  width of column/pulse counters (max line 4095 px)
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              asynchronous reset, active-high
//  in_valid   in   1              sample presented to datapath this cycle
//  in_last    in   1              qualifies in_valid: last sample of line
//  in_ready   out  1              controller will accept sample (dp_wen fires on in_valid&in_ready)
//  dp_wen     out  1              datapath advance strobe (wen of norm/corr wrapper)
//  dp_flush   out  1              datapath wrapper must force sample inputs to 0 while high
//  corr_bus   in   NUM_DISP*16    corr_out_0..N packed, corr_out_0 in [15:0]
//  out_valid  out  1              result valid
//  out_ready  in   1              result consumer ready
//  out_disp   out  4              winning disparity index
//  out_score  out  16             winning correlation value (unsigned)
//  out_col    out  COL_W          column of result within line
//  line_done  out  1              one-cycle pulse when flush of a line completes
// BEHAVIOUR
//  Reset: state IDLE; in_ready=0 during rst, 1 in first cycle after; dp_wen=dp_flush=out_valid=line_done=0; out_disp/out_score/out_col=0; counters=0.
//  States: IDLE, RUN, SCAN, HOLD, FLUSH.
//  IDLE/RUN: in_ready=1; accept -> dp_wen=1 same cycle (combinational), pulse counter npulse++; IDLE->RUN on first accept.
//  Result rule: pulse number n (1-based within line) with n>PIPE_LAT carries column c=n-1-PIPE_LAT.
//   If c>=NUM_DISP-1 -> SCAN next cycle; else result dropped (left shift chain not full).
//  Accept with in_last: remember last; if no result due -> FLUSH, else SCAN then FLUSH after HOLD.
//  SCAN: in_ready=0; cycle 0 snapshots corr_bus; then NUM_DISP cycles compare index 0..NUM_DISP-1.
//   Replace best only if strictly greater (tie -> lowest index). Exactly NUM_DISP+1 cycles, then HOLD.
//  HOLD: out_valid=1, outputs stable until out_valid&out_ready.
//   Handshake cycle -> RUN, or FLUSH if last seen and flush pulses remain, else IDLE + line_done.
//   out_valid never drops without handshake.
//  FLUSH: dp_wen=1, dp_flush=1 one cycle per visit, in_ready=0; applies same result rule.
//   Total PIPE_LAT flush pulses per line, then line_done pulse and IDLE; npulse cleared for next line.
//  Line of L samples -> max(0, L-NUM_DISP+1) results; columns NUM_DISP-1..L-1 in order.
//  in_last on a line with L<NUM_DISP: flush runs, no results, line_done still pulses.
//  npulse saturates at 2^COL_W-1; further results carry out_col=all-ones.
//  Async rst mid-line/mid-SCAN/HOLD: everything abandoned; datapath contents are stale, first PIPE_LAT+NUM_DISP-1 pulses of next line produce no results anyway.
//  dp_wen asserted at most once per accepted sample or flush step; never in SCAN/HOLD.
// CONFIGURATION
//  NORM_CORR_SEQ_THRESH_EN defined: adds input min_score[15:0].
//   If final best < min_score, out_disp=4'hF (no match); out_score still reports best.
//  Undefined: no min_score port; out_disp always the argmax index.
// TESTING
//  Reset mid-HOLD (out_valid=1) -> next cycle out_valid=0, dp_wen=0; after release in_ready=1, IDLE.
//  Line L=20, corr_bus constant with corr_out_3=100, rest 10, out_ready=1.
//   -> 10 results, out_col 10..19, out_disp=3, out_score=100; 6 flush pulses; one line_done.
//  Tie: corr_out_2=corr_out_7=500, rest 0 -> out_disp=2, out_score=500.
//  Backpressure: out_ready=0 for 20 cycles in HOLD -> outputs stable, in_ready=0, no dp_wen;
//   release -> exactly one handshake, resume RUN.
//  Short line L=5 with in_last -> 6 dp_wen with dp_flush=1, zero out_valid, line_done after 6th flush.
//  THRESH_EN, min_score=200, best=150 at index 4 -> out_disp=4'hF, out_score=150;
//   min_score=150 -> out_disp=4.

Source files
------------

// File: rtl/norm_corr_seq_ctrl.sv
// norm_corr_seq_ctrl
// Sequencer for the normalise+correlate datapath (norm -> NUM_DISP-disparity corr bank).
//  - Accepts pixel samples on i_in_valid/o_in_ready and strobes o_dp_wen once per accepted sample.
//  - Counts datapath pulses per line to know when a valid correlation result sits on i_corr_bus.
//  - Snapshots the corr bank and serially picks the best disparity (strictly greater wins, ties keep
//    the lowest index), then presents it on o_out_valid/i_out_ready.
//  - After the last sample of a line, issues PIPE_LAT flush pulses (o_dp_flush) to drain the pipe,
//    then pulses o_line_done.
// Optional feature: define NORM_CORR_SEQ_THRESH_EN to add i_min_score; a best score below it is
// reported as o_out_disp = 4'hF (no match) while o_out_score still carries the best value.
// Ports:
//  i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//  i_in_valid, i_in_last sample handshake in; i_in_last marks the last sample of a line
//  o_in_ready            controller accepts a sample this cycle
//  o_dp_wen, o_dp_flush  datapath advance strobe; flush forces datapath sample inputs to zero
//  i_corr_bus            NUM_DISP packed 16-bit correlation values, index 0 in [15:0]
//  o_out_valid, i_out_ready  result handshake
//  o_out_disp, o_out_score, o_out_col  winning disparity, its score, column within line
//  o_line_done           one-cycle pulse when the flush of a line completes
//  i_min_score           (NORM_CORR_SEQ_THRESH_EN only) minimum score for a match
module norm_corr_seq_ctrl #(
  parameter int NUM_DISP = 11,
  parameter int PIPE_LAT = 6,
  parameter int COL_W    = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_in_valid,
  input  logic                  i_in_last,
  output logic                  o_in_ready,
  output logic                  o_dp_wen,
  output logic                  o_dp_flush,
  input  logic [NUM_DISP*16-1:0] i_corr_bus,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [3:0]            o_out_disp,
  output logic [15:0]           o_out_score,
  output logic [COL_W-1:0]      o_out_col,
  output logic                  o_line_done
`ifdef NORM_CORR_SEQ_THRESH_EN
  ,
  input  logic [15:0]           i_min_score
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_SCAN  = 3'd2,
    S_HOLD  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  localparam int SCW = $clog2(NUM_DISP + 1);
  localparam int FLW = $clog2(PIPE_LAT + 1);
  // First 1-based pulse number whose result has a full left shift chain.
  localparam logic [COL_W-1:0] RES_N     = COL_W'(PIPE_LAT + NUM_DISP);
  localparam logic [COL_W-1:0] COL_OFS   = COL_W'(PIPE_LAT + 1);
  localparam logic [SCW-1:0]   SCAN_LAST = SCW'(NUM_DISP);
  localparam logic [FLW-1:0]   FL_LAST   = FLW'(PIPE_LAT - 1);
  localparam logic [FLW-1:0]   FL_ALL    = FLW'(PIPE_LAT);

  state_t                 r_state, w_state_nx;
  logic                   r_in_ready, r_out_valid, r_line_done, r_last_seen;
  logic [COL_W-1:0]       r_npulse, r_res_col, r_out_col;
  logic [FLW-1:0]         r_nflush;
  logic [SCW-1:0]         r_scan_cnt;
  logic [NUM_DISP*16-1:0] r_snap;
  logic [15:0]            r_best_score, r_out_score;
  logic [3:0]             r_best_idx, r_out_disp;

  logic                   w_dp_wen, w_dp_flush, w_line_end, w_accept;
  logic                   w_sat, w_due, w_take, w_no_match;
  logic [COL_W-1:0]       w_n_next, w_col;
  logic [15:0]            w_cur, w_bsc;
  logic [3:0]             w_idx, w_bix;

  // Pulse number this strobe would carry; saturates so very long lines keep a sane counter.
  assign w_sat    = &r_npulse;
  assign w_n_next = w_sat ? r_npulse : (r_npulse + COL_W'(1));
  assign w_due    = (w_n_next >= RES_N);
  assign w_col    = w_sat ? {COL_W{1'b1}} : (w_n_next - COL_OFS);

  // Serial compare: the snapshot shifts down one word per cycle, first compare always loads.
  assign w_cur  = r_snap[15:0];
  assign w_idx  = 4'(r_scan_cnt - SCW'(1));
  assign w_take = (r_scan_cnt == SCW'(1)) || (w_cur > r_best_score);
  assign w_bsc  = w_take ? w_cur : r_best_score;
  assign w_bix  = w_take ? w_idx : r_best_idx;

`ifdef NORM_CORR_SEQ_THRESH_EN
  assign w_no_match = (w_bsc < i_min_score);
`else
  assign w_no_match = 1'b0;
`endif

  assign w_accept    = i_in_valid && r_in_ready;
  assign o_in_ready  = r_in_ready;
  assign o_dp_wen    = w_dp_wen;
  assign o_dp_flush  = w_dp_flush;
  assign o_out_valid = r_out_valid;
  assign o_out_disp  = r_out_disp;
  assign o_out_score = r_out_score;
  assign o_out_col   = r_out_col;
  assign o_line_done = r_line_done;

  // Next-state and strobe decode.
  always_comb begin
    w_state_nx = r_state;
    w_dp_wen   = 1'b0;
    w_dp_flush = 1'b0;
    w_line_end = 1'b0;
    case (r_state)
      S_IDLE, S_RUN: begin
        if (w_accept) begin
          w_dp_wen = 1'b1;
          if (w_due) begin
            w_state_nx = S_SCAN;
          end else if (i_in_last) begin
            w_state_nx = S_FLUSH;
          end else begin
            w_state_nx = S_RUN;
          end
        end else begin
          w_state_nx = r_state;
        end
      end
      S_SCAN: begin
        if (r_scan_cnt == SCAN_LAST) begin
          w_state_nx = S_HOLD;
        end else begin
          w_state_nx = S_SCAN;
        end
      end
      S_HOLD: begin
        if (i_out_ready) begin
          if (!r_last_seen) begin
            w_state_nx = S_RUN;
          end else if (r_nflush != FL_ALL) begin
            w_state_nx = S_FLUSH;
          end else begin
            w_state_nx = S_IDLE;
            w_line_end = 1'b1;
          end
        end else begin
          w_state_nx = S_HOLD;
        end
      end
      S_FLUSH: begin
        w_dp_wen   = 1'b1;
        w_dp_flush = 1'b1;
        if (w_due) begin
          w_state_nx = S_SCAN;
        end else if (r_nflush == FL_LAST) begin
          w_state_nx = S_IDLE;
          w_line_end = 1'b1;
        end else begin
          w_state_nx = S_FLUSH;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State, handshake flags and per-line counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_line_done <= 1'b0;
      r_last_seen <= 1'b0;
      r_npulse    <= '0;
      r_nflush    <= '0;
      r_res_col   <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_in_ready  <= (w_state_nx == S_IDLE) || (w_state_nx == S_RUN);
      r_out_valid <= (w_state_nx == S_HOLD);
      r_line_done <= w_line_end;
      if (w_line_end) begin
        r_npulse    <= '0;
        r_nflush    <= '0;
        r_last_seen <= 1'b0;
      end else begin
        if (w_dp_wen) begin
          r_npulse <= w_n_next;
        end
        if (w_dp_flush) begin
          r_nflush <= r_nflush + FLW'(1);
        end
        if (w_accept && i_in_last) begin
          r_last_seen <= 1'b1;
        end
      end
      if (w_dp_wen && w_due) begin
        r_res_col <= w_col;
      end
    end
  end

  // Snapshot, serial argmax and result output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scan_cnt   <= '0;
      r_snap       <= '0;
      r_best_score <= 16'd0;
      r_best_idx   <= 4'd0;
      r_out_disp   <= 4'd0;
      r_out_score  <= 16'd0;
      r_out_col    <= '0;
    end else if (r_state == S_SCAN) begin
      if (r_scan_cnt == SCW'(0)) begin
        r_snap <= i_corr_bus;
      end else begin
        r_snap       <= {16'd0, r_snap[NUM_DISP*16-1:16]};
        r_best_score <= w_bsc;
        r_best_idx   <= w_bix;
      end
      if (r_scan_cnt == SCAN_LAST) begin
        r_scan_cnt  <= '0;
        r_out_score <= w_bsc;
        r_out_disp  <= w_no_match ? 4'hF : w_bix;
        r_out_col   <= r_res_col;
      end else begin
        r_scan_cnt <= r_scan_cnt + SCW'(1);
      end
    end else begin
      r_scan_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_norm_corr_seq_ctrl.sv
// Directed bench for norm_corr_seq_ctrl (NUM_DISP=11, PIPE_LAT=6, COL_W=12).
module tb_norm_corr_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_last, out_ready;
  logic         in_ready, dp_wen, dp_flush, out_valid, line_done;
  logic [175:0] corr_bus;
  logic [3:0]   out_disp;
  logic [15:0]  out_score;
  logic [11:0]  out_col;
`ifdef NORM_CORR_SEQ_THRESH_EN
  logic [15:0]  min_score;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Monitor counters (written only by the monitor process).
  int n_wen = 0, n_flush = 0, n_res = 0, n_done = 0, n_bad = 0, cyc = 0;
  int last_flush_cyc = 0, done_cyc = 0;
  int q_col[$];
  int q_disp[$];
  int q_score[$];

  // Backpressure helpers.
  int g, bp_err, bp_rdy, bp_wen;
  logic [3:0]  cap_d;
  logic [15:0] cap_s;
  logic [11:0] cap_c;
  int b_wen, b_flush, b_res, b_done;

  always #5 clk = ~clk;

  norm_corr_seq_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_in_last(in_last),
    .o_in_ready(in_ready), .o_dp_wen(dp_wen), .o_dp_flush(dp_flush),
    .i_corr_bus(corr_bus), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_disp(out_disp), .o_out_score(out_score), .o_out_col(out_col),
    .o_line_done(line_done)
`ifdef NORM_CORR_SEQ_THRESH_EN
    , .i_min_score(min_score)
`endif
  );

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (dp_wen) n_wen <= n_wen + 1;
      if (dp_wen && dp_flush) begin
        n_flush <= n_flush + 1;
        last_flush_cyc <= cyc;
      end
      if (out_valid && out_ready) begin
        n_res <= n_res + 1;
        q_col.push_back(int'(out_col));
        q_disp.push_back(int'(out_disp));
        q_score.push_back(int'(out_score));
      end
      if (line_done) begin
        n_done <= n_done + 1;
        done_cyc <= cyc;
      end
      if (dp_wen && out_valid) n_bad <= n_bad + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_corr(input int ia, input int va, input int ib, input int vb, input int rest);
    for (int k = 0; k < 11; k++) begin
      corr_bus[k*16 +: 16] = (k == ia) ? 16'(va) : ((k == ib) ? 16'(vb) : 16'(rest));
    end
  endtask

  task automatic mark();
    b_wen = n_wen; b_flush = n_flush; b_res = n_res; b_done = n_done;
  endtask

  task automatic send_line(input int len);
    int guard;
    for (int i = 1; i <= len; i++) begin
      in_valid = 1'b1;
      in_last  = (i == len);
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 2000) check_val("send_timeout", 32'(guard), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (n_done == b_done && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check_val("done_timeout", 32'(guard < 2000), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic check_results(input string tag, input int cnt, input int col0, input int d, input int s);
    check_val({tag, "_nres"}, 32'(n_res - b_res), 32'(cnt));
    for (int k = 0; k < cnt && (b_res + k) < q_col.size(); k++) begin
      check_val({tag, "_col"},   32'(q_col[b_res + k]),   32'(col0 + k));
      check_val({tag, "_disp"},  32'(q_disp[b_res + k]),  32'(d));
      check_val({tag, "_score"}, 32'(q_score[b_res + k]), 32'(s));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    corr_bus = '0;
`ifdef NORM_CORR_SEQ_THRESH_EN
    min_score = 16'd0;
`endif
    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_dp_wen", 32'(dp_wen), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_line_done", 32'(line_done), 32'd0);
    check_val("rst_outputs", {16'(out_score), 4'(out_disp), 12'(out_col)}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check_val("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Line of 20: 10 results, cols 10..19, disp 3 score 100
    set_corr(3, 100, 3, 100, 10);
    mark();
    send_line(20);
    wait_done();
    check_results("l20", 10, 10, 3, 100);
    check_val("l20_flush", 32'(n_flush - b_flush), 32'd6);
    check_val("l20_wen", 32'(n_wen - b_wen), 32'd26);
    check_val("l20_done", 32'(n_done - b_done), 32'd1);

    // Tie between index 2 and 7: lowest index wins; L=11 gives a single result at col 10
    set_corr(2, 500, 7, 500, 0);
    mark();
    send_line(11);
    wait_done();
    check_results("tie", 1, 10, 2, 500);

    // Backpressure: result held 20 cycles, then one handshake and back to RUN
    set_corr(9, 5, 9, 5, 1);
    out_ready = 1'b0;
    mark();
    fork
      send_line(18);
      begin
        g = 0;
        while (!out_valid && g < 2000) begin
          @(negedge clk);
          g++;
        end
        check_val("bp_valid_seen", 32'(out_valid), 32'd1);
        cap_d = out_disp; cap_s = out_score; cap_c = out_col;
        bp_err = 0; bp_rdy = 0; bp_wen = 0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (!out_valid || out_disp != cap_d || out_score != cap_s || out_col != cap_c) bp_err++;
          if (in_ready) bp_rdy++;
          if (dp_wen) bp_wen++;
        end
        check_val("bp_stable", 32'(bp_err), 32'd0);
        check_val("bp_in_ready", 32'(bp_rdy), 32'd0);
        check_val("bp_dp_wen", 32'(bp_wen), 32'd0);
        check_val("bp_no_hs", 32'(n_res - b_res), 32'd0);
        check_val("bp_held", {16'(cap_s), 4'(cap_d), 12'(cap_c)}, {16'd5, 4'd9, 12'd10});
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("bp_one_hs", 32'(n_res - b_res), 32'd1);
        check_val("bp_resume_ready", 32'(in_ready), 32'd1);
        check_val("bp_valid_drop", 32'(out_valid), 32'd0);
      end
    join
    wait_done();
    check_results("bp", 8, 10, 9, 5);

    // Short line: no results, six flush pulses, line_done right after the sixth
    mark();
    send_line(5);
    wait_done();
    check_val("short_nres", 32'(n_res - b_res), 32'd0);
    check_val("short_flush", 32'(n_flush - b_flush), 32'd6);
    check_val("short_wen", 32'(n_wen - b_wen), 32'd11);
    check_val("short_done", 32'(n_done - b_done), 32'd1);
    check_val("short_done_gap", 32'(done_cyc - last_flush_cyc), 32'd1);

`ifdef NORM_CORR_SEQ_THRESH_EN
    set_corr(4, 150, 4, 150, 10);
    min_score = 16'd200;
    mark();
    send_line(11);
    wait_done();
    check_results("thr200", 1, 10, 15, 150);
    min_score = 16'd150;
    mark();
    send_line(11);
    wait_done();
    check_results("thr150", 1, 10, 4, 150);
    min_score = 16'd0;
`endif

    // Reset while a result is held
    out_ready = 1'b0;
    in_valid = 1'b1; in_last = 1'b0;
    g = 0;
    while (!out_valid && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check_val("mid_hold_reached", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_val("mid_rst_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_wen", 32'(dp_wen), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check_val("mid_rel_ready", 32'(in_ready), 32'd1);
    check_val("mid_rel_valid", 32'(out_valid), 32'd0);

    check_val("wen_in_hold", 32'(n_bad), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
